// File: rtl/motor_guard.sv
// Dual-channel H-bridge guard: enforces dead time on direct reversal and latches
// overcurrent faults with timed retry, independently for right and left motors.
module motor_guard_ch #(
    parameter int unsigned DEAD_CYCLES = 100000,
    parameter int unsigned FAULT_HOLD  = 10000000,
    parameter int unsigned OC_FILTER   = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic f_i,
    input  logic b_i,
    input  logic pwm_i,
    input  logic oc_i,
    output logic f_o,
    output logic b_o,
    output logic pwm_o,
    output logic fault_o
);
    localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam int HW = (FAULT_HOLD > 1) ? $clog2(FAULT_HOLD) : 1;
    localparam int OW = $clog2(OC_FILTER + 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(FAULT_HOLD - 1);
    localparam logic [OW-1:0] OC_LAST   = OW'(OC_FILTER - 1);
    localparam logic [OW-1:0] OC_MAX    = OW'(OC_FILTER);

    typedef enum logic [1:0] {RUN, DEAD, FAULT} state_t;
    typedef enum logic [1:0] {DIR_STOP, DIR_FWD, DIR_REV} dir_t;

    logic          fin_q, bin_q, pwmin_q;
    logic          oc_s1_q, oc_s2_q;
    state_t        state_q, state_d;
    dir_t          dir_q, dir_d, cmd;
    logic [DW-1:0] dead_cnt_q, dead_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [OW-1:0] oc_cnt_q, oc_cnt_d;
    logic          oc_trip;
    logic          f_q, f_d, b_q, b_d, pwm_q, pwm_d, fault_q, fault_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_q      <= 1'b0;
            bin_q      <= 1'b0;
            pwmin_q    <= 1'b0;
            oc_s1_q    <= 1'b0;
            oc_s2_q    <= 1'b0;
            state_q    <= RUN;
            dir_q      <= DIR_STOP;
            dead_cnt_q <= '0;
            hold_cnt_q <= '0;
            oc_cnt_q   <= '0;
            f_q        <= 1'b0;
            b_q        <= 1'b0;
            pwm_q      <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            fin_q      <= f_i;
            bin_q      <= b_i;
            pwmin_q    <= pwm_i;
            oc_s1_q    <= oc_i;
            oc_s2_q    <= oc_s1_q;
            state_q    <= state_d;
            dir_q      <= dir_d;
            dead_cnt_q <= dead_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            oc_cnt_q   <= oc_cnt_d;
            f_q        <= f_d;
            b_q        <= b_d;
            pwm_q      <= pwm_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        cmd        = DIR_STOP;
        state_d    = state_q;
        dir_d      = dir_q;
        dead_cnt_d = dead_cnt_q;
        hold_cnt_d = hold_cnt_q;
        oc_cnt_d   = '0;
        oc_trip    = 1'b0;

        if (fin_q && !bin_q)      cmd = DIR_FWD;
        else if (!fin_q && bin_q) cmd = DIR_REV;

        // Counter saturates at OC_FILTER so the trip fires once per high streak.
        if (oc_s2_q) begin
            oc_cnt_d = (oc_cnt_q == OC_MAX) ? oc_cnt_q : oc_cnt_q + OW'(1);
            oc_trip  = (oc_cnt_q == OC_LAST);
        end

        case (state_q)
            RUN: begin
                if (cmd != dir_q) begin
                    if (cmd != DIR_STOP && dir_q != DIR_STOP) begin
                        state_d    = DEAD;
                        dead_cnt_d = '0;
                    end else begin
                        dir_d = cmd;
                    end
                end
            end
            DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = RUN;
                    dir_d   = cmd;
                end else begin
                    dead_cnt_d = dead_cnt_q + DW'(1);
                end
            end
            FAULT: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    if (!oc_s2_q) begin
                        state_d = RUN;
                        dir_d   = DIR_STOP;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            default: begin
                state_d = RUN;
                dir_d   = DIR_STOP;
            end
        endcase

        if (oc_trip && state_q != FAULT) begin
            state_d    = FAULT;
            hold_cnt_d = '0;
        end

        // Drive is derived from next state so F and B can never overlap.
        f_d     = (state_d == RUN) && (dir_d == DIR_FWD);
        b_d     = (state_d == RUN) && (dir_d == DIR_REV);
        pwm_d   = (state_d == RUN) && (dir_d != DIR_STOP) && pwmin_q;
        fault_d = (state_d == FAULT);
    end

    assign f_o     = f_q;
    assign b_o     = b_q;
    assign pwm_o   = pwm_q;
    assign fault_o = fault_q;
endmodule

module motor_guard #(
    parameter int unsigned DEAD_CYCLES = 100000,
    parameter int unsigned FAULT_HOLD  = 10000000,
    parameter int unsigned OC_FILTER   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RMF_in,
    input  logic       RMB_in,
    input  logic       LMF_in,
    input  logic       LMB_in,
    input  logic       RM_pwm_in,
    input  logic       LM_pwm_in,
    input  logic       RM_oc,
    input  logic       LM_oc,
    output logic       RMF,
    output logic       RMB,
    output logic       LMF,
    output logic       LMB,
    output logic       RM_pwm,
    output logic       LM_pwm,
    output logic [1:0] fault
);
    motor_guard_ch #(
        .DEAD_CYCLES(DEAD_CYCLES), .FAULT_HOLD(FAULT_HOLD), .OC_FILTER(OC_FILTER)
    ) u_right (
        .clk(clk), .rst_n(rst_n),
        .f_i(RMF_in), .b_i(RMB_in), .pwm_i(RM_pwm_in), .oc_i(RM_oc),
        .f_o(RMF), .b_o(RMB), .pwm_o(RM_pwm), .fault_o(fault[0])
    );

    motor_guard_ch #(
        .DEAD_CYCLES(DEAD_CYCLES), .FAULT_HOLD(FAULT_HOLD), .OC_FILTER(OC_FILTER)
    ) u_left (
        .clk(clk), .rst_n(rst_n),
        .f_i(LMF_in), .b_i(LMB_in), .pwm_i(LM_pwm_in), .oc_i(LM_oc),
        .f_o(LMF), .b_o(LMB), .pwm_o(LM_pwm), .fault_o(fault[1])
    );
endmodule

// File: tb/tb_motor_guard.sv
// Bench for motor_guard: directed scenarios plus random traffic, checked every cycle
// against a behavioural model using countdown timers and run-length oc tracking.
module tb_motor_guard;
    localparam int DC = 4;
    localparam int FH = 8;
    localparam int OF = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       RMF_in = 0, RMB_in = 0, LMF_in = 0, LMB_in = 0;
    logic       RM_pwm_in = 0, LM_pwm_in = 0, RM_oc = 0, LM_oc = 0;
    logic       RMF, RMB, LMF, LMB, RM_pwm, LM_pwm;
    logic [1:0] fault;

    motor_guard #(.DEAD_CYCLES(DC), .FAULT_HOLD(FH), .OC_FILTER(OF)) dut (
        .clk(clk), .rst_n(rst_n),
        .RMF_in(RMF_in), .RMB_in(RMB_in), .LMF_in(LMF_in), .LMB_in(LMB_in),
        .RM_pwm_in(RM_pwm_in), .LM_pwm_in(LM_pwm_in),
        .RM_oc(RM_oc), .LM_oc(LM_oc),
        .RMF(RMF), .RMB(RMB), .LMF(LMF), .LMB(LMB),
        .RM_pwm(RM_pwm), .LM_pwm(LM_pwm), .fault(fault)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, index 0 = right, 1 = left. mode: 0 run, 1 dead, 2 fault.
    // dir: +1 forward, -1 reverse, 0 stop. timer counts cycles remaining in dead/fault.
    int m_mode[2], m_dir[2], m_timer[2], m_run[2];
    bit m_f[2], m_b[2], m_p[2], m_s1[2], m_s2[2];
    bit e_f[2], e_b[2], e_p[2], e_flt[2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_mode[c] = 0; m_dir[c] = 0; m_timer[c] = 0; m_run[c] = 0;
            m_f[c] = 0; m_b[c] = 0; m_p[c] = 0; m_s1[c] = 0; m_s2[c] = 0;
            e_f[c] = 0; e_b[c] = 0; e_p[c] = 0; e_flt[c] = 0;
        end
    endfunction

    function automatic void model_edge();
        bit fi[2], bi[2], pi[2], oi[2];
        fi[0] = RMF_in; bi[0] = RMB_in; pi[0] = RM_pwm_in; oi[0] = RM_oc;
        fi[1] = LMF_in; bi[1] = LMB_in; pi[1] = LM_pwm_in; oi[1] = LM_oc;
        for (int c = 0; c < 2; c++) begin
            int cmd;
            int old;
            bit oc;
            cmd = (m_f[c] && !m_b[c]) ? 1 : ((!m_f[c] && m_b[c]) ? -1 : 0);
            oc  = m_s2[c];
            old = m_mode[c];
            m_run[c] = oc ? m_run[c] + 1 : 0;
            if (old == 0) begin
                if (cmd != m_dir[c]) begin
                    if (cmd != 0 && m_dir[c] != 0) begin
                        m_mode[c] = 1; m_timer[c] = DC;
                    end else begin
                        m_dir[c] = cmd;
                    end
                end
            end else if (old == 1) begin
                m_timer[c]--;
                if (m_timer[c] == 0) begin
                    m_mode[c] = 0; m_dir[c] = cmd;
                end
            end else begin
                m_timer[c]--;
                if (m_timer[c] == 0) begin
                    if (oc) m_timer[c] = FH;
                    else begin
                        m_mode[c] = 0; m_dir[c] = 0;
                    end
                end
            end
            if (oc && m_run[c] == OF && old != 2) begin
                m_mode[c] = 2; m_timer[c] = FH;
            end
            e_f[c]   = (m_mode[c] == 0) && (m_dir[c] == 1);
            e_b[c]   = (m_mode[c] == 0) && (m_dir[c] == -1);
            e_p[c]   = (m_mode[c] == 0) && (m_dir[c] != 0) && m_p[c];
            e_flt[c] = (m_mode[c] == 2);
            m_s2[c] = m_s1[c]; m_s1[c] = oi[c];
            m_f[c] = fi[c]; m_b[c] = bi[c]; m_p[c] = pi[c];
        end
    endfunction

    function automatic logic [7:0] dut_vec();
        return {RMF, RMB, RM_pwm, LMF, LMB, LM_pwm, fault};
    endfunction

    function automatic logic [7:0] exp_vec();
        return {e_f[0], e_b[0], e_p[0], e_f[1], e_b[1], e_p[1], e_flt[1], e_flt[0]};
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        check(tag, dut_vec(), exp_vec());
        check("excl", {6'b0, RMF & RMB, LMF & LMB}, 8'h00);
    endtask

    task automatic steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check(tag, dut_vec(), 8'h00);
        model_reset();
        step(tag);
        rst_n = 1'b1;
    endtask

    int zeros;
    int burst[2];

    initial begin
        model_reset();
        steps(2, "reset");
        check("reset_state", dut_vec(), 8'h00);
        rst_n = 1'b1;

        RMF_in = 1; RM_pwm_in = 1;
        step("fwd_lat1");
        check("fwd_not_early", dut_vec(), 8'h00);
        step("fwd_lat2");
        check("fwd_out", dut_vec(), 8'b101_000_00);

        LMF_in = 1; LM_pwm_in = 1;
        steps(3, "left_fwd");
        RMF_in = 0; RMB_in = 1;
        step("rev_req");
        zeros = 0;
        for (int i = 0; i < 10; i++) begin
            step("dead");
            if (RMB) break;
            if ({RMF, RMB, RM_pwm} == 3'b000) zeros++;
        end
        check("dead_len", 8'(zeros), 8'd4);
        check("dead_exit", dut_vec(), 8'b011_101_00);

        RMB_in = 0;              step("stop");
        RMF_in = 1;              step("fwd");
        RMF_in = 0;              step("stop2");
        RMF_in = 1;              steps(3, "fwd2");
        check("no_dead", dut_vec(), 8'b101_101_00);
        RMB_in = 1;              steps(2, "illegal");
        check("illegal", {6'b0, RMF, RMB}, 8'h00);
        RMB_in = 0;              steps(3, "fwd3");

        LM_oc = 1;               steps(2, "oc_short");
        LM_oc = 0;               steps(5, "oc_short_lo");
        check("oc_short_nofault", {6'b0, fault}, 8'h00);
        LM_oc = 1;               steps(6, "oc_long");
        check("oc_fault", dut_vec(), 8'b101_000_10);
        LM_oc = 0;               steps(14, "oc_recover");
        check("oc_cleared", {6'b0, fault}, 8'h00);
        LM_oc = 1;               steps(30, "oc_hold");
        check("oc_held", {6'b0, fault}, 8'b10);
        LM_oc = 0;               steps(14, "oc_hold_rel");

        RMF_in = 0; RMB_in = 1; RM_oc = 1;
        steps(6, "oc_dead");
        check("oc_dead_fault", {6'b0, fault}, 8'b01);
        RM_oc = 0;               steps(14, "oc_dead_rel");

        RMF_in = 1; RMB_in = 0;  steps(4, "pre_rst");
        async_reset("rst_mid_dead");
        steps(3, "post_rst");

        burst[0] = 0; burst[1] = 0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) {RMF_in, RMB_in} = 2'($urandom);
            if ($urandom_range(0, 7) == 0) {LMF_in, LMB_in} = 2'($urandom);
            RM_pwm_in = 1'($urandom);
            LM_pwm_in = 1'($urandom);
            for (int c = 0; c < 2; c++) begin
                if (burst[c] == 0 && $urandom_range(0, 39) == 0) burst[c] = $urandom_range(1, 14);
            end
            RM_oc = (burst[0] > 0);
            LM_oc = (burst[1] > 0);
            if (burst[0] > 0) burst[0]--;
            if (burst[1] > 0) burst[1]--;
            if ($urandom_range(0, 499) == 0) async_reset("rand_rst");
            else step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/motor_guard.md
MOTOR_GUARD -- requirements
Module: motor_guard

Interface
REQ-001 The block SHALL provide parameter DEAD_CYCLES, default 100000: clocks of all-off dead time on direct direction reversal (1 ms at 100 MHz).
REQ-002 The block SHALL provide parameter FAULT_HOLD, default 10000000: clocks held in fault before retry (100 ms).
REQ-003 The block SHALL provide parameter OC_FILTER, default 16: consecutive synchronized-high clocks on an oc input required to declare overcurrent.
REQ-004 Port clk, input, 1: system clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-006 Ports RMF_in, RMB_in, LMF_in, LMB_in, input, 1 each: raw direction commands from the line-follow controller.
REQ-007 Ports RM_pwm_in, LM_pwm_in, input, 1 each: raw PWM from the line-follow controller.
REQ-008 Ports RM_oc, LM_oc, input, 1 each: asynchronous overcurrent flags from the H-bridge; high = overcurrent.
REQ-009 Ports RMF, RMB, LMF, LMB, RM_pwm, LM_pwm, output, 1 each: guarded drive to the H-bridge (JC pins); all registered.
REQ-010 Port fault, output, 2: bit0 = right motor in FAULT, bit1 = left motor in FAULT; registered.

Function
REQ-011 Right and left motors SHALL each have an independent, identical guard channel; nothing is shared except clk and rst_n.
REQ-012 Command decode: F=1,B=0 -> FWD; F=0,B=1 -> REV; F=0,B=0 -> STOP; F=1,B=1 (illegal) -> STOP.
REQ-013 Direction and PWM inputs SHALL be registered once; oc inputs SHALL pass a 2-flop synchronizer.
REQ-014 Latency: a direction/PWM input sampled at edge k SHALL appear on the outputs after edge k+1 (2 cycles) in RUN.
REQ-015 Each channel SHALL hold an applied direction (FWD/REV/STOP) and an FSM with states RUN, DEAD, FAULT.
REQ-016 RUN: outputs = applied direction (FWD -> F=1,B=0; REV -> F=0,B=1; STOP -> 0,0); pwm = registered pwm when applied != STOP, else 0.
REQ-017 RUN, new decoded command differs from applied and neither is STOP (FWD<->REV) -> DEAD; dead counter loaded to 0; F, B, pwm forced 0 from the next cycle.
REQ-018 RUN, transition to or from STOP (including illegal) SHALL update the applied direction immediately, with no dead time.
REQ-019 DEAD: outputs 0; counter increments each cycle; at count DEAD_CYCLES-1 -> RUN, applied = decoded command of that cycle (re-evaluated, not the one that triggered DEAD).
REQ-020 Command changes during DEAD SHALL NOT restart the counter.
REQ-021 Overcurrent filter: a counter increments while the synchronized oc=1 and clears to 0 when oc=0; reaching OC_FILTER -> FAULT from any state, preempting DEAD.
REQ-022 FAULT: F, B, pwm = 0; fault bit = 1; hold counter runs FAULT_HOLD cycles.
REQ-023 At FAULT_HOLD expiry: if synchronized oc=1, the hold counter SHALL reload and the channel stays in FAULT; else -> RUN with applied = STOP, fault bit cleared the same edge.
REQ-024 Counters SHALL be sized to hold the largest parameter value; no wrap-around is permitted within any state.
REQ-025 Outputs SHALL never present F=1 and B=1 together, in any state or cycle.

Reset
REQ-026 While rst_n=0: all outputs 0, fault=2'b00, FSM=RUN, applied=STOP, all counters and synchronizer/input registers 0.
REQ-027 Reset asserted mid-DEAD or mid-FAULT SHALL abort the state immediately; after release, the first input sample is seen on outputs 2 cycles later.

Verification (DEAD_CYCLES=4, FAULT_HOLD=8, OC_FILTER=3)
REQ-028 Reset, then RMF_in=1, RM_pwm_in=1 -> RMF=1, RM_pwm=1 two edges later; RMB=0, fault=00.
REQ-029 RUN FWD, switch to RMB_in=1,RMF_in=0 -> RMF=RMB=RM_pwm=0 for exactly 4 cycles, then RMB=1; left channel unaffected.
REQ-030 FWD -> STOP -> FWD on consecutive cycles -> no dead time; outputs follow with 2-cycle latency; RMF_in=RMB_in=1 -> outputs 0,0.
REQ-031 LM_oc high 2 cycles then low -> no fault; high 3+ cycles -> fault[1]=1, LM outputs 0; oc dropped -> after 8 cycles fault[1]=0, LM in STOP, then follows command.
REQ-032 oc held high through FAULT_HOLD expiry -> fault stays 1 and the hold restarts; oc during DEAD -> FAULT preempts.
REQ-033 rst_n pulsed low mid-DEAD -> all outputs 0 asynchronously; resumes from STOP after release.
